// File: rtl/sync_fifo_ctlr.sv
// sync_fifo_ctlr
// Pointer, occupancy and status controller for a single-clock FIFO built
// around an external RAM. The RAM data path is not part of this block; only
// the enables and addresses are produced here, so read latency is whatever
// the RAM provides.
//
// Optional feature: define SYNC_FIFO_WMARK_EN to build the peak-occupancy
// watermark register. Without it o_wmark is tied to zero.
//
// Parameters
//   PTR_WIDTH    RAM address width, DEPTH = 2**PTR_WIDTH entries
//   LVL_WIDTH    width of level / threshold / watermark values (PTR_WIDTH+1)
// Ports
//   i_clk         single clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_push/i_pop  write / read requests
//   i_afull_lvl   almost-full threshold  (o_afull  = level >= threshold)
//   i_aempty_lvl  almost-empty threshold (o_aempty = level <= threshold)
//   i_clr_err     clears sticky error flags, reloads watermark
//   o_wren/o_wptr RAM write enable / address
//   o_rden/o_rptr RAM read enable / address
//   o_full/o_empty, o_afull/o_aempty  status
//   o_level       occupancy 0..DEPTH
//   o_ovf/o_udf   sticky overflow / underflow
//   o_wmark       peak occupancy since reset or last clear
module sync_fifo_ctlr #(
  parameter int PTR_WIDTH = 4,
  parameter int LVL_WIDTH = PTR_WIDTH + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [LVL_WIDTH-1:0] i_afull_lvl,
  input  logic [LVL_WIDTH-1:0] i_aempty_lvl,
  input  logic                 i_clr_err,
  output logic                 o_wren,
  output logic [PTR_WIDTH-1:0] o_wptr,
  output logic                 o_rden,
  output logic [PTR_WIDTH-1:0] o_rptr,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic [LVL_WIDTH-1:0] o_level,
  output logic                 o_ovf,
  output logic                 o_udf,
  output logic [LVL_WIDTH-1:0] o_wmark
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [LVL_WIDTH-1:0] level;
  logic [LVL_WIDTH-1:0] level_nxt;
  logic                 ovf;
  logic                 udf;

  // Status comes from the registered level only, so a push into a full FIFO
  // is rejected even if a pop is accepted in the same cycle.
  assign o_full  = (level == LVL_FULL);
  assign o_empty = (level == '0);

  // Enables are gated by reset so nothing reaches the RAM while in reset.
  assign o_wren = i_rst_n & i_push & ~o_full;
  assign o_rden = i_rst_n & i_pop  & ~o_empty;

  assign o_afull  = (level >= i_afull_lvl);
  assign o_aempty = (level <= i_aempty_lvl);

  assign o_wptr  = wptr;
  assign o_rptr  = rptr;
  assign o_level = level;
  assign o_ovf   = ovf;
  assign o_udf   = udf;

  // Level changes only when exactly one side is accepted.
  always_comb begin
    level_nxt = level;
    case ({o_wren, o_rden})
      2'b10:   level_nxt = level + LVL_WIDTH'(1);
      2'b01:   level_nxt = level - LVL_WIDTH'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers wrap naturally at DEPTH because they are PTR_WIDTH bits wide.
  // A new error event wins over a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (o_wren) wptr <= wptr + PTR_WIDTH'(1);
      if (o_rden) rptr <= rptr + PTR_WIDTH'(1);
      level <= level_nxt;
      ovf   <= (i_push & o_full)  | (ovf & ~i_clr_err);
      udf   <= (i_pop  & o_empty) | (udf & ~i_clr_err);
    end
  end

`ifdef SYNC_FIFO_WMARK_EN
  logic [LVL_WIDTH-1:0] wmark;

  // A clear restarts peak tracking from the occupancy at the time of the
  // clear rather than from zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wmark <= '0;
    end else if (i_clr_err) begin
      wmark <= level;
    end else if (level_nxt > wmark) begin
      wmark <= level_nxt;
    end
  end

  assign o_wmark = wmark;
`else
  assign o_wmark = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctlr.sv
// tb_sync_fifo_ctlr
// Self-checking bench for sync_fifo_ctlr with PTR_WIDTH=3 (DEPTH=8).
// The reference model keeps the FIFO as a queue of the RAM addresses that
// hold live entries plus totals of accepted writes and reads; every cycle
// all outputs are compared against what that model predicts.
module tb_sync_fifo_ctlr;

  localparam int PW    = 3;
  localparam int LW    = PW + 1;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rstN;
  logic          push;
  logic          pop;
  logic          clrErr;
  logic [LW-1:0] afullLvl;
  logic [LW-1:0] aemptyLvl;
  logic          oWren;
  logic [PW-1:0] oWptr;
  logic          oRden;
  logic [PW-1:0] oRptr;
  logic          oFull;
  logic          oEmpty;
  logic          oAfull;
  logic          oAempty;
  logic [LW-1:0] oLevel;
  logic          oOvf;
  logic          oUdf;
  logic [LW-1:0] oWmark;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model state
  int addrQ[$];
  int wCount;
  int rCount;
  bit mOvf;
  bit mUdf;
  int mWmark;

  sync_fifo_ctlr #(.PTR_WIDTH(PW), .LVL_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_push(push), .i_pop(pop),
    .i_afull_lvl(afullLvl), .i_aempty_lvl(aemptyLvl), .i_clr_err(clrErr),
    .o_wren(oWren), .o_wptr(oWptr), .o_rden(oRden), .o_rptr(oRptr),
    .o_full(oFull), .o_empty(oEmpty), .o_afull(oAfull), .o_aempty(oAempty),
    .o_level(oLevel), .o_ovf(oOvf), .o_udf(oUdf), .o_wmark(oWmark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, compare every output with
  // the model just before the rising edge, then advance the model.
  task automatic applyStimulus(input bit rstn, input bit p, input bit q, input bit clr);
    int  lvl;
    bit  isFull;
    bit  isEmpty;
    bit  wrOk;
    bit  rdOk;
    bit  newOvf;
    bit  newUdf;
    @(negedge clk);
    rstN   = rstn;
    push   = p;
    pop    = q;
    clrErr = clr;
    #1;
    lvl     = addrQ.size();
    isFull  = (lvl == DEPTH);
    isEmpty = (lvl == 0);
    wrOk    = rstn && p && !isFull;
    rdOk    = rstn && q && !isEmpty;
    checkOutput("wren",   oWren,   wrOk);
    checkOutput("rden",   oRden,   rdOk);
    checkOutput("wptr",   oWptr,   wCount % DEPTH);
    checkOutput("rptr",   oRptr,   rCount % DEPTH);
    checkOutput("level",  oLevel,  lvl);
    checkOutput("full",   oFull,   isFull);
    checkOutput("empty",  oEmpty,  isEmpty);
    checkOutput("afull",  oAfull,  lvl >= int'(afullLvl));
    checkOutput("aempty", oAempty, lvl <= int'(aemptyLvl));
    checkOutput("ovf",    oOvf,    mOvf);
    checkOutput("udf",    oUdf,    mUdf);
`ifdef SYNC_FIFO_WMARK_EN
    checkOutput("wmark",  oWmark,  mWmark);
`else
    checkOutput("wmark",  oWmark,  0);
`endif
    if (!isEmpty) checkOutput("rptrHead", oRptr, addrQ[0]);

    if (!rstn) begin
      addrQ.delete();
      wCount = 0;
      rCount = 0;
      mOvf   = 1'b0;
      mUdf   = 1'b0;
      mWmark = 0;
    end else begin
      newOvf = (p && isFull)  || (mOvf && !clr);
      newUdf = (q && isEmpty) || (mUdf && !clr);
      if (rdOk) begin
        void'(addrQ.pop_front());
        rCount++;
      end
      if (wrOk) begin
        addrQ.push_back(wCount % DEPTH);
        wCount++;
      end
      mOvf = newOvf;
      mUdf = newUdf;
      if (clr) mWmark = lvl;
      else if (addrQ.size() > mWmark) mWmark = addrQ.size();
    end
  endtask

  task automatic runCycles(input int n, input bit rstn, input bit p, input bit q, input bit clr);
    for (int i = 0; i < n; i++) applyStimulus(rstn, p, q, clr);
  endtask

  // Move past the rising edge that commits the last applied cycle.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clrErr    = 1'b0;
    afullLvl  = LW'(6);
    aemptyLvl = LW'(2);
    wCount    = 0;
    rCount    = 0;
    mOvf      = 1'b0;
    mUdf      = 1'b0;
    mWmark    = 0;

    // Reset, including requests held during reset
    runCycles(2, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(2, 1'b0, 1'b1, 1'b1, 1'b0);

    // Fill and overflow
    runCycles(8, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("fillLevel", oLevel, 8);
    checkOutput("fillFull",  oFull,  1);
    checkOutput("fillWptr",  oWptr,  0);
    runCycles(1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("fillOvf", oOvf, 1);

    // Drain and underflow
    runCycles(9, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("drainEmpty", oEmpty, 1);
    checkOutput("drainRptr",  oRptr,  0);
    checkOutput("drainUdf",   oUdf,   1);

    // Simultaneous push and pop at the boundaries and mid-level
    runCycles(1, 1'b1, 1'b0, 1'b0, 1'b1);
    runCycles(1, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("simEmptyLevel", oLevel, 1);
    checkOutput("simEmptyUdf",   oUdf,   1);
    runCycles(7, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(1, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("simFullLevel", oLevel, 7);
    checkOutput("simFullOvf",   oOvf,   1);
    runCycles(3, 1'b1, 1'b0, 1'b1, 1'b0);
    runCycles(3, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("simMidLevel", oLevel, 4);

    // Clear versus simultaneous overflow
    runCycles(4, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    checkOutput("clrWithOvf", oOvf, 1);
    runCycles(1, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    checkOutput("clrAlone", oOvf, 0);

    // Watermark after fill to 5 and drain, then reset at level 5
    runCycles(1, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(5, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(5, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
`ifdef SYNC_FIFO_WMARK_EN
    checkOutput("wmarkPeak", oWmark, 5);
`else
    checkOutput("wmarkTied", oWmark, 0);
`endif
    runCycles(5, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("rstLevel", oLevel, 0);
    checkOutput("rstEmpty", oEmpty, 1);
    checkOutput("rstWptr",  oWptr,  0);
    checkOutput("rstRptr",  oRptr,  0);
    checkOutput("rstOvf",   oOvf,   0);

    // Randomized traffic with varying thresholds, clears and rare resets
    for (int i = 0; i < 3000; i++) begin
      bit rr;
      bit pp;
      bit qq;
      bit cc;
      int bias;
      bias = (i / 200) % 3;
      rr = ($urandom_range(0, 199) != 0);
      pp = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      qq = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      cc = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) begin
        afullLvl  = LW'($urandom_range(0, 9));
        aemptyLvl = LW'($urandom_range(0, 9));
      end
      applyStimulus(rr, pp, qq, cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
    $finish;
  end

endmodule
